apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL provide parameter: TIMEOUT_CYCLES, 16, number of consecutive ACCESS cycles with PREADY=0 before abort (timeout build only; legal 1..255).
REQ-002 SHALL have port: clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: cmd_valid  input  1  local request valid.
REQ-005 SHALL have port: cmd_ready  output  1  master can accept a request.
REQ-006 SHALL have port: cmd_write  input  1  1=write, 0=read.
REQ-007 SHALL have port: cmd_addr  input  32  transfer address.
REQ-008 SHALL have port: cmd_wdata  input  32  write data.
REQ-009 SHALL have port: rsp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: rsp_rdata  output  32  read data; 0 for writes and aborts.
REQ-011 SHALL have port: rsp_err  output  1  completion error (PSLVERR or timeout).
REQ-012 SHALL have ports: PADDR output 32, PWRITE output 1, PSEL output 1, PENABLE output 1, PWDATA output 32 -- APB requester outputs.
REQ-013 SHALL have ports: PRDATA input 32, PREADY input 1, PSLVERR input 1 -- APB completer responses.

Function
REQ-014 SHALL implement FSM states IDLE, SETUP, ACCESS; all APB and rsp outputs registered.
REQ-015 cmd_ready SHALL be 1 only in IDLE; request accepted on cmd_valid&&cmd_ready, capturing cmd_write/addr/wdata.
REQ-016 Accept in IDLE SHALL move to SETUP next cycle: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA = captured values.
REQ-017 SETUP SHALL always move to ACCESS after exactly one cycle: PSEL=1, PENABLE=1.
REQ-018 ACCESS SHALL persist while PREADY=0; PADDR/PWRITE/PWDATA/PSEL/PENABLE held stable throughout.
REQ-019 ACCESS with PREADY=1 SHALL complete: next cycle IDLE, PSEL=0, PENABLE=0, rsp_valid=1 for one cycle, rsp_err=PSLVERR sampled at completion edge.
REQ-020 Read completion SHALL set rsp_rdata=PRDATA sampled at completion edge; write completion SHALL set rsp_rdata=0.
REQ-021 PRDATA/PSLVERR SHALL be ignored except when PSEL&&PENABLE&&PREADY.
REQ-022 Zero-wait-state throughput SHALL be one transfer per 3 cycles; a new command may be accepted in the same cycle rsp_valid is high.
REQ-023 PADDR/PWRITE/PWDATA SHALL retain last values in IDLE; rsp_rdata/rsp_err SHALL retain values until next completion.
REQ-024 cmd_valid while cmd_ready=0 SHALL be ignored (no queueing); requester must hold it.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0; cmd_ready=1 after reset.
REQ-026 Reset during SETUP/ACCESS SHALL drop the transfer without rsp_valid.

Configuration
REQ-027 Macro APB_MASTER_TIMEOUT_EN defined: counter counts ACCESS cycles with PREADY=0, cleared on entering SETUP; on reaching TIMEOUT_CYCLES, next cycle IDLE, PSEL=PENABLE=0, rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-028 PREADY=1 in the same cycle the count reaches TIMEOUT_CYCLES SHALL complete normally (PREADY wins).
REQ-029 Macro undefined: no counter logic; ACCESS waits indefinitely for PREADY.

Verification
REQ-030 Write addr 0x10, data 0xDEADBEEF, PREADY=1 -> SETUP cycle then ACCESS cycle with PADDR=0x10, PWDATA=0xDEADBEEF; rsp_valid, rsp_err=0, rsp_rdata=0 on 3rd cycle after accept.
REQ-031 Read addr 0x20, PREADY low 3 ACCESS cycles, PRDATA=0x12345678 -> signals stable for 4 ACCESS cycles; rsp_rdata=0x12345678.
REQ-032 Read with PSLVERR=1 at PREADY=1 -> rsp_err=1, rsp_rdata=PRDATA value.
REQ-033 With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY stuck 0 -> abort after 4 ACCESS cycles, rsp_err=1, rsp_rdata=0; PREADY=1 on 4th cycle -> normal completion.
REQ-034 Back-to-back writes with cmd_valid held high -> accepts every 3 cycles, PSEL low exactly one cycle between transfers; rst_n pulsed in ACCESS -> outputs zero, no rsp_valid.

Source files
------------

// File: rtl/apb_master.sv
// APB requester: turns single local commands into APB SETUP/ACCESS transfers.
// Optional ACCESS-phase timeout abort is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic        PSEL,
  output logic        PENABLE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
    $error("apb_master: TIMEOUT_CYCLES must be 1..255");
  end

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       accept;
  logic       done;
  logic       to_hit;

  assign cmd_ready = (state == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  // Completer response only counts inside a live ACCESS phase.
  assign done      = PSEL && PENABLE && PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [8:0] TO_LIM = 9'(TIMEOUT_CYCLES);

  logic [7:0] to_cnt;

  // Abort fires when this stalled cycle brings the count to the limit;
  // a PREADY in the same cycle takes priority.
  assign to_hit = (state == S_ACCESS) && !PREADY &&
                  (({1'b0, to_cnt} + 9'd1) >= TO_LIM);

  // Count stalled ACCESS cycles; restart for every new transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= 8'd0;
    end else if (accept) begin
      to_cnt <= 8'd0;
    end else if (state == S_ACCESS && !PREADY) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // Next-state selection for the three-phase transfer.
  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      state == S_IDLE: begin
        if (accept) state_nxt = S_SETUP;
      end
      state == S_SETUP: begin
        state_nxt = S_ACCESS;
      end
      state == S_ACCESS: begin
        if (done || to_hit) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register plus the registered APB strobes derived from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
    end else begin
      state   <= state_nxt;
      PSEL    <= (state_nxt != S_IDLE);
      PENABLE <= (state_nxt == S_ACCESS);
    end
  end

  // Address/control/data are captured on accept and held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PADDR  <= 32'd0;
      PWRITE <= 1'b0;
      PWDATA <= 32'd0;
    end else if (accept) begin
      PADDR  <= cmd_addr;
      PWRITE <= cmd_write;
      PWDATA <= cmd_wdata;
    end
  end

  // Completion pulse and sticky response payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= done || to_hit;
      if (done) begin
        rsp_rdata <= PWRITE ? 32'd0 : PRDATA;
        rsp_err   <= PSLVERR;
      end else if (to_hit) begin
        rsp_rdata <= 32'd0;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master with a scripted APB completer.
// Build with APB_MASTER_TIMEOUT_EN to exercise the abort path (limit 4).
module tb_apb_master;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rdata = '0;
  logic        exp_err = 1'b0;

  always #5 clk = ~clk;

  apb_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // One transfer from an IDLE cycle to its response cycle.
  // waits = number of ACCESS cycles with PREADY low before PREADY high.
  task automatic do_xfer(input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input int waits,
                         input logic [31:0] rd, input bit err,
                         input bit hold, input string nm);
    bit abort;
    int n_acc;
    abort = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    abort = (waits >= TO);
`endif
    n_acc = abort ? TO : waits + 1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_ready got %b want 1", nm, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = wd;
    PREADY  = 1'($urandom);
    PRDATA  = $urandom;
    PSLVERR = 1'($urandom);
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
    else begin
      cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = 1'($urandom);
    end
    checks++;
    if ({PSEL, PENABLE, PWRITE, cmd_ready, rsp_valid} !== {1'b1, 1'b0, wr, 1'b0, 1'b0}
        || PADDR !== a || PWDATA !== wd) begin
      errors++;
      $display("FAIL %s setup got sel/en/wr/rdy/rv=%b%b%b%b%b addr=%h wd=%h want 10%b00 addr=%h wd=%h",
               nm, PSEL, PENABLE, PWRITE, cmd_ready, rsp_valid, PADDR, PWDATA, wr, a, wd);
    end
    @(posedge clk); #1;
    for (int i = 0; i < n_acc; i++) begin
      checks++;
      if ({PSEL, PENABLE, PWRITE, cmd_ready, rsp_valid} !== {1'b1, 1'b1, wr, 1'b0, 1'b0}
          || PADDR !== a || PWDATA !== wd) begin
        errors++;
        $display("FAIL %s access%0d got sel/en/wr/rdy/rv=%b%b%b%b%b addr=%h wd=%h want 11%b00 addr=%h wd=%h",
                 nm, i, PSEL, PENABLE, PWRITE, cmd_ready, rsp_valid, PADDR, PWDATA, wr, a, wd);
      end
      PREADY  = (i == waits);
      PRDATA  = (i == waits) ? rd : $urandom;
      PSLVERR = (i == waits) ? err : 1'($urandom);
      if (hold) begin
        cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    exp_rdata = (abort || wr) ? 32'd0 : rd;
    exp_err   = abort ? 1'b1 : err;
    checks++;
    if ({PSEL, PENABLE, rsp_valid, cmd_ready, rsp_err} !== {4'b0011, exp_err}
        || rsp_rdata !== exp_rdata || PADDR !== a || PWDATA !== wd || PWRITE !== wr) begin
      errors++;
      $display("FAIL %s done got sel/en/rv/rdy/err=%b%b%b%b%b rdata=%h addr=%h want 0011%b rdata=%h addr=%h",
               nm, PSEL, PENABLE, rsp_valid, cmd_ready, rsp_err, rsp_rdata, PADDR,
               exp_err, exp_rdata, a);
    end
    PREADY = 1'b0;
  endtask

  // One idle cycle: pulse must be gone, payload retained.
  task automatic idle_check(input string nm);
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid, PSEL, PENABLE, cmd_ready} !== 4'b0001
        || rsp_rdata !== exp_rdata || rsp_err !== exp_err) begin
      errors++;
      $display("FAIL %s idle got rv/sel/en/rdy=%b%b%b%b rdata=%h err=%b want 0001 rdata=%h err=%b",
               nm, rsp_valid, PSEL, PENABLE, cmd_ready, rsp_rdata, rsp_err, exp_rdata, exp_err);
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready} !== 6'b000001
        || PADDR !== 0 || PWDATA !== 0 || rsp_rdata !== 0) begin
      errors++;
      $display("FAIL reset got sel/en/wr/rv/err/rdy=%b%b%b%b%b%b addr=%h wd=%h rd=%h want 000001 zeros",
               PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready, PADDR, PWDATA, rsp_rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_rdata = 0;
    exp_err = 0;
    idle_check("post_reset");
  endtask

  task automatic test_write_basic;
    @(posedge clk); #1;
    do_xfer(1'b1, 32'h10, 32'hDEADBEEF, 0, 32'hA5A5A5A5, 1'b0, 1'b0, "write_basic");
    idle_check("write_basic");
  endtask

  task automatic test_read_wait;
    do_xfer(1'b0, 32'h20, 32'h0, 3, 32'h12345678, 1'b0, 1'b0, "read_wait");
    idle_check("read_wait");
  endtask

  task automatic test_read_err;
    do_xfer(1'b0, 32'h30, 32'h0, 1, 32'hCAFEF00D, 1'b1, 1'b0, "read_err");
    idle_check("read_err");
  endtask

  task automatic test_timeout;
`ifdef APB_MASTER_TIMEOUT_EN
    do_xfer(1'b0, 32'h40, 32'h0, TO + 3, 32'h11112222, 1'b0, 1'b0, "timeout_abort");
    idle_check("timeout_abort");
    do_xfer(1'b0, 32'h44, 32'h0, TO - 1, 32'h33334444, 1'b0, 1'b0, "timeout_edge");
    idle_check("timeout_edge");
`else
    do_xfer(1'b0, 32'h40, 32'h0, 20, 32'h55556666, 1'b0, 1'b0, "long_wait");
    idle_check("long_wait");
`endif
  endtask

  task automatic test_random;
    for (int n = 0; n < 24; n++) begin
      do_xfer(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 6)),
              $urandom, 1'($urandom), 1'b0, "random");
      if ($urandom_range(0, 1) == 1) idle_check("random");
    end
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 4; n++) begin
      do_xfer(1'b1, 32'h100 + 32'(n * 4), $urandom, 0, $urandom, 1'b0, 1'b1, "b2b");
    end
    cmd_valid = 1'b0;
    idle_check("b2b");
  endtask

  task automatic test_reset_mid;
    cmd_valid = 1'b1; cmd_write = 1'b1;
    cmd_addr = 32'hABCD0000; cmd_wdata = 32'h87654321;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    PREADY = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready} !== 6'b000001
        || PADDR !== 0 || PWDATA !== 0 || rsp_rdata !== 0) begin
      errors++;
      $display("FAIL reset_mid got sel/en/wr/rv/err/rdy=%b%b%b%b%b%b addr=%h wd=%h want 000001 zeros",
               PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, cmd_ready, PADDR, PWDATA);
    end
    PREADY = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    PREADY = 1'b0;
    exp_rdata = 0;
    exp_err = 0;
    for (int i = 0; i < 3; i++) idle_check("reset_mid");
    do_xfer(1'b0, 32'h50, 32'h0, 2, 32'h0BADCAFE, 1'b0, 1'b0, "after_reset");
    idle_check("after_reset");
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_wait();
    test_read_err();
    test_timeout();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
